hdr_sequencer: RTL and testbench
================================

Name: hdr_sequencer

Overview:
- Parametrised successor of the HDR engine. Sequences a stream of HDR command descriptors across one CCC engine and NUM_ENG normal-transfer engines (DDR, TSP, TSL, BT).
- Inserts the dummy CCC phase (SPECIAL_ADDR) when a restarted CCC is followed by a normal transfer.
- Adds a per-transfer watchdog, invalid-descriptor detection and a completed-transfer counter.
- Sits between the i3c engine and the HDR sub-engines, and drives the sub-engine output muxes.

Parameters:
- NUM_ENG, 4, number of normal-transfer engines (1..7).
- ADDR_W, 12, register-file address width.
- DEFAULT_ADDR, 1000, idle value of o_regf_addr_special.
- SPECIAL_ADDR, 450, dummy-value address used in the DUMMY phase.
- HDR_MODE, 6, i_mode code meaning HDR active.
- TIMEOUT_CYC, 1024, maximum cycles a sub-engine may stay enabled without done (>=2).
- CNT_W, 8, transfer counter width.

Ports:
- i_sys_clk  in  1  system clock.
- i_sys_rst  in  1  reset, synchronous, active-high.
- i_hdrengine_en  in  1  level enable from the i3c engine; low aborts.
- i_cp  in  1  descriptor: 1 = CCC, 0 = normal transfer.
- i_toc  in  1  descriptor: 1 = exit after this transfer, 0 = restart.
- i_eng_idx  in  3  descriptor: normal engine index.
- i_mode  in  3  current bus mode.
- i_ccc_done  in  1  CCC engine completion pulse.
- i_eng_done  in  NUM_ENG  per-engine completion pulses.
- o_ccc_en  out  1  CCC engine enable.
- o_eng_en  out  NUM_ENG  one-hot normal engine enable.
- o_path_sel  out  3  mux select: 0 = CCC, k+1 = engine k.
- o_regf_addr_special  out  ADDR_W  special regfile address.
- o_hdrengine_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky error (timeout or invalid index).
- o_xfer_cnt  out  CNT_W  completed transfers since reset.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; o_ccc_en, o_eng_en, o_path_sel, o_hdrengine_done, o_err, o_xfer_cnt = 0; o_regf_addr_special = DEFAULT_ADDR; internal ccc_restart flag = 0.
- IDLE:
  - i_hdrengine_en=1 -> DISPATCH.
  - o_err clears on leaving IDLE.
- DISPATCH (1 cycle): latch i_cp, i_toc, i_eng_idx, then evaluate in order:
  - i_mode != HDR_MODE -> DONE.
  - i_cp=1 -> RUN; o_ccc_en=1, o_path_sel=0.
  - i_eng_idx >= NUM_ENG -> o_err=1, DONE.
  - ccc_restart=1 -> DUMMY; o_ccc_en=1, o_path_sel=0, addr=SPECIAL_ADDR.
  - else -> RUN; o_eng_en[idx]=1, o_path_sel=idx+1.
- Latency: i_hdrengine_en high at edge N gives an enable high after edge N+2.
- DUMMY: on i_ccc_done:
  - o_ccc_en=0, addr=DEFAULT_ADDR, ccc_restart=0.
  - Next cycle: o_eng_en[latched idx]=1, o_path_sel=idx+1, state RUN.
  - The dummy phase does not increment o_xfer_cnt.
- RUN: wait for the done of the selected engine only; done from a non-selected engine is ignored. On done:
  - Drop the enable and increment o_xfer_cnt (wraps at 2^CNT_W).
  - ccc_restart = latched cp & ~latched toc.
  - If latched toc=1 or i_mode != HDR_MODE -> DONE, else -> DISPATCH.
- Mode loss: i_mode != HDR_MODE during RUN/DUMMY with no done -> drop enables, addr=DEFAULT_ADDR, DONE; the counter is not incremented.
- Watchdog:
  - Counter clears on entry to RUN/DUMMY and increments each cycle there.
  - At TIMEOUT_CYC-1 without done -> drop enables, addr=DEFAULT_ADDR, o_err=1, DONE.
  - Done in the same cycle as expiry: done wins, no error.
- DONE: o_hdrengine_done=1 for exactly one cycle, ccc_restart=0, o_path_sel held, then IDLE.
- Abort: i_hdrengine_en=0 in any non-IDLE state -> next cycle all enables 0, addr=DEFAULT_ADDR, ccc_restart=0, state IDLE, no done pulse. o_err and o_xfer_cnt are retained.
- Reset asserted mid-transfer returns to reset values on the next edge.
- o_eng_en and o_ccc_en are never high simultaneously; at most one bit of o_eng_en is high.

Test Plan:
- Single DDR write: cp=0, toc=1, idx=0; engine done after 20 cycles -> o_eng_en=0001 two edges after en, o_path_sel=1, then one o_hdrengine_done pulse, o_xfer_cnt=1.
- CCC restart then DDR: (cp=1, toc=0), then (cp=0, idx=2, toc=1) -> CCC runs; DUMMY with addr=450, o_ccc_en=1; after i_ccc_done, addr=1000, o_eng_en=0100, o_path_sel=3; final done pulse, o_xfer_cnt=2.
- Back-to-back DDR restarts idx 0,1,3 with toc=0,0,1 -> no DUMMY, o_path_sel 1,2,4 in sequence, o_xfer_cnt=3, one done pulse.
- Timeout: engine never responds, TIMEOUT_CYC=16 -> enable drops after 16 cycles, o_err=1, done pulse; o_err clears on the next transaction start. Done on cycle 15 -> no error.
- Invalid idx=5 with NUM_ENG=4 -> no enable asserted, o_err=1, done pulse. Also: i_mode changes 6->0 mid-RUN -> enable drops, done pulse, counter unchanged.
- Abort: i_hdrengine_en low mid-CCC -> o_ccc_en=0 next cycle, IDLE, no done pulse. Also: i_sys_rst mid-DUMMY -> addr=1000, all outputs at reset values.

Source files
------------

// File: rtl/hdr_sequencer.sv
// HDR command sequencer: walks descriptors across one CCC engine and NUM_ENG
// normal-transfer engines, inserting a dummy CCC phase after a restarted CCC.
module hdr_sequencer #(
  parameter int NUM_ENG      = 4,
  parameter int ADDR_W       = 12,
  parameter int DEFAULT_ADDR = 1000,
  parameter int SPECIAL_ADDR = 450,
  parameter int HDR_MODE     = 6,
  parameter int TIMEOUT_CYC  = 1024,
  parameter int CNT_W        = 8
) (
  input  logic               i_sys_clk,
  input  logic               i_sys_rst,
  input  logic               i_hdrengine_en,
  input  logic               i_cp,
  input  logic               i_toc,
  input  logic [2:0]         i_eng_idx,
  input  logic [2:0]         i_mode,
  input  logic               i_ccc_done,
  input  logic [NUM_ENG-1:0] i_eng_done,
  output logic               o_ccc_en,
  output logic [NUM_ENG-1:0] o_eng_en,
  output logic [2:0]         o_path_sel,
  output logic [ADDR_W-1:0]  o_regf_addr_special,
  output logic               o_hdrengine_done,
  output logic               o_err,
  output logic [CNT_W-1:0]   o_xfer_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DISPATCH = 3'd1;
  localparam logic [2:0] S_EVAL     = 3'd2;
  localparam logic [2:0] S_DUMMY    = 3'd3;
  localparam logic [2:0] S_SWITCH   = 3'd4;
  localparam logic [2:0] S_RUN      = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0]  ADDR_DEF  = ADDR_W'(DEFAULT_ADDR);
  localparam logic [ADDR_W-1:0]  ADDR_SPC  = ADDR_W'(SPECIAL_ADDR);
  localparam logic [2:0]         MODE_HDR  = 3'(HDR_MODE);
  localparam logic [3:0]         ENG_LIMIT = 4'(NUM_ENG);
  localparam logic [NUM_ENG-1:0] ENG_ONE   = NUM_ENG'(1);

  logic [2:0]      state;
  logic            cp_q;
  logic            toc_q;
  logic [2:0]      idx_q;
  logic            ccc_restart;
  logic [WD_W-1:0] wd_cnt;

  logic mode_ok;
  logic sel_done;
  logic wd_expired;

  assign mode_ok    = (i_mode == MODE_HDR);
  // Only the engine currently enabled may complete the transfer.
  assign sel_done   = cp_q ? i_ccc_done : |(i_eng_done & o_eng_en);
  assign wd_expired = (wd_cnt == WD_LAST);

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state               <= S_IDLE;
      cp_q                <= 1'b0;
      toc_q               <= 1'b0;
      idx_q               <= '0;
      ccc_restart         <= 1'b0;
      wd_cnt              <= '0;
      o_ccc_en            <= 1'b0;
      o_eng_en            <= '0;
      o_path_sel          <= '0;
      o_regf_addr_special <= ADDR_DEF;
      o_hdrengine_done    <= 1'b0;
      o_err               <= 1'b0;
      o_xfer_cnt          <= '0;
    end else begin
      o_hdrengine_done <= 1'b0;
      if (state != S_IDLE && !i_hdrengine_en) begin
        o_ccc_en            <= 1'b0;
        o_eng_en            <= '0;
        o_regf_addr_special <= ADDR_DEF;
        ccc_restart         <= 1'b0;
        state               <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_hdrengine_en) begin
              o_err <= 1'b0;
              state <= S_DISPATCH;
            end
          end
          S_DISPATCH: begin
            cp_q  <= i_cp;
            toc_q <= i_toc;
            idx_q <= i_eng_idx;
            state <= S_EVAL;
          end
          S_EVAL: begin
            wd_cnt <= '0;
            if (!mode_ok) begin
              o_hdrengine_done <= 1'b1;
              state            <= S_DONE;
            end else if (cp_q) begin
              o_ccc_en   <= 1'b1;
              o_path_sel <= 3'd0;
              state      <= S_RUN;
            end else if ({1'b0, idx_q} >= ENG_LIMIT) begin
              o_err            <= 1'b1;
              o_hdrengine_done <= 1'b1;
              state            <= S_DONE;
            end else if (ccc_restart) begin
              o_ccc_en            <= 1'b1;
              o_path_sel          <= 3'd0;
              o_regf_addr_special <= ADDR_SPC;
              state               <= S_DUMMY;
            end else begin
              o_eng_en   <= ENG_ONE << idx_q;
              o_path_sel <= idx_q + 3'd1;
              state      <= S_RUN;
            end
          end
          S_DUMMY: begin
            if (i_ccc_done) begin
              o_ccc_en            <= 1'b0;
              o_regf_addr_special <= ADDR_DEF;
              ccc_restart         <= 1'b0;
              state               <= S_SWITCH;
            end else if (!mode_ok || wd_expired) begin
              o_ccc_en            <= 1'b0;
              o_regf_addr_special <= ADDR_DEF;
              o_err               <= o_err | mode_ok;
              o_hdrengine_done    <= 1'b1;
              state               <= S_DONE;
            end else begin
              wd_cnt <= wd_cnt + WD_W'(1);
            end
          end
          S_SWITCH: begin
            o_eng_en   <= ENG_ONE << idx_q;
            o_path_sel <= idx_q + 3'd1;
            wd_cnt     <= '0;
            state      <= S_RUN;
          end
          S_RUN: begin
            if (sel_done) begin
              o_ccc_en   <= 1'b0;
              o_eng_en   <= '0;
              o_xfer_cnt <= o_xfer_cnt + CNT_W'(1);
              if (toc_q || !mode_ok) begin
                o_hdrengine_done <= 1'b1;
                state            <= S_DONE;
              end else begin
                ccc_restart <= cp_q & ~toc_q;
                state       <= S_DISPATCH;
              end
            end else if (!mode_ok || wd_expired) begin
              // Mode loss aborts quietly; only watchdog expiry flags an error.
              o_ccc_en            <= 1'b0;
              o_eng_en            <= '0;
              o_regf_addr_special <= ADDR_DEF;
              o_err               <= o_err | mode_ok;
              o_hdrengine_done    <= 1'b1;
              state               <= S_DONE;
            end else begin
              wd_cnt <= wd_cnt + WD_W'(1);
            end
          end
          S_DONE: begin
            ccc_restart <= 1'b0;
            state       <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdr_sequencer.sv
// Bench for hdr_sequencer: a descriptor-level model builds the expected
// per-cycle output trace, which a compare process checks against the DUT.
module tb_hdr_sequencer;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst, en, cp, toc, ccc_done;
  logic [2:0] idx, mode;
  logic [3:0] eng_done;
  logic        o_ccc_en, o_hdrengine_done, o_err;
  logic [3:0]  o_eng_en, o_xfer_cnt;
  logic [2:0]  o_path_sel;
  logic [11:0] o_regf_addr_special;

  hdr_sequencer #(.NUM_ENG(4), .ADDR_W(12), .DEFAULT_ADDR(1000), .SPECIAL_ADDR(450),
                  .HDR_MODE(6), .TIMEOUT_CYC(T), .CNT_W(4)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_hdrengine_en(en), .i_cp(cp), .i_toc(toc),
    .i_eng_idx(idx), .i_mode(mode), .i_ccc_done(ccc_done), .i_eng_done(eng_done),
    .o_ccc_en(o_ccc_en), .o_eng_en(o_eng_en), .o_path_sel(o_path_sel),
    .o_regf_addr_special(o_regf_addr_special), .o_hdrengine_done(o_hdrengine_done),
    .o_err(o_err), .o_xfer_cnt(o_xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst, en, cp, toc; logic [2:0] idx, mode; logic ccc_done; logic [3:0] eng_done;
  } in_t;
  typedef struct packed {
    logic ccc_en; logic [3:0] eng_en; logic [2:0] path; logic [11:0] addr;
    logic done, err; logic [3:0] cnt;
  } exp_t;
  typedef struct {
    bit cp, toc; bit [2:0] idx; int d, loss, abort_at, dd, drst; bit evloss;
  } desc_t;

  in_t   g;
  exp_t  m;
  bit    m_restart;
  exp_t  exp_q[$];
  exp_t  e_c, a_c;
  int    checks, errors, done_seen, cyc, base;
  bit    pin_on, ended;
  desc_t x;

  // compare process: every cycle with a queued expectation
  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() != 0) begin
      e_c = exp_q.pop_front();
      a_c = {o_ccc_en, o_eng_en, o_path_sel, o_regf_addr_special, o_hdrengine_done, o_err, o_xfer_cnt};
      checks++;
      if (a_c !== e_c) begin
        errors++;
        $display("FAIL trace cyc %0d: got ccc=%b eng=%b path=%0d addr=%0d done=%b err=%b cnt=%0d, expected ccc=%b eng=%b path=%0d addr=%0d done=%b err=%b cnt=%0d",
                 cyc, a_c.ccc_en, a_c.eng_en, a_c.path, a_c.addr, a_c.done, a_c.err, a_c.cnt,
                 e_c.ccc_en, e_c.eng_en, e_c.path, e_c.addr, e_c.done, e_c.err, e_c.cnt);
      end
      if (o_hdrengine_done === 1'b1) done_seen++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic pin();
    @(posedge clk); #2;
  endtask

  task automatic step();
    @(negedge clk);
    {rst, en, cp, toc, idx, mode, ccc_done, eng_done} = g;
    exp_q.push_back(m);
    g.ccc_done = 1'b0; g.eng_done = '0; m.done = 1'b0;
  endtask

  task automatic reset_model();
    m = '0; m.addr = 12'd1000; m_restart = 1'b0;
  endtask

  task automatic drop();
    m.ccc_en = 1'b0; m.eng_en = '0; m.addr = 12'd1000;
  endtask

  task automatic to_done();
    m.done = 1'b1; m_restart = 1'b0; step();
    g.en = 1'b0; step();
  endtask

  task automatic noise();
    if ($urandom_range(0, 2) == 0) begin
      g.eng_done = 4'($urandom_range(0, 15)) & ~m.eng_en;
      if (m.eng_en != 0) g.ccc_done = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic start();
    g.en = 1'b1; g.mode = 3'd6; m.err = 1'b0; step();
  endtask

  task automatic idle(input int n);
    g.en = 1'b0; g.mode = 3'd6;
    repeat (n) begin
      g.cp = 1'($urandom); g.idx = 3'($urandom); g.eng_done = 4'($urandom);
      step();
    end
  endtask

  function automatic desc_t mk(bit c, bit t, bit [2:0] i, int d);
    desc_t r;
    r.cp = c; r.toc = t; r.idx = i; r.d = d;
    r.loss = 0; r.abort_at = 0; r.dd = 3; r.drst = 0; r.evloss = 1'b0;
    return r;
  endfunction

  task automatic run_phase(input desc_t y, output bit fin);
    fin = 1'b1;
    for (int k = 1; k <= T; k++) begin
      if (k == y.abort_at) begin
        g.en = 1'b0; drop(); m_restart = 1'b0; step(); return;
      end
      if (k == y.d) begin
        if (y.cp) g.ccc_done = 1'b1; else g.eng_done[y.idx[1:0]] = 1'b1;
        if (k == y.loss) g.mode = 3'd0;
        m.ccc_en = 1'b0; m.eng_en = '0; m.cnt = m.cnt + 4'd1;
        if (y.toc || g.mode != 3'd6) to_done();
        else begin m_restart = y.cp; step(); fin = 1'b0; end
        return;
      end
      if (k == y.loss) begin g.mode = 3'd0; drop(); to_done(); return; end
      if (k == T) begin drop(); m.err = 1'b1; to_done(); return; end
      noise(); step();
    end
  endtask

  task automatic desc(input desc_t y, output bit fin);
    fin = 1'b1;
    g.cp = y.cp; g.toc = y.toc; g.idx = y.idx; step();
    g.cp = 1'($urandom); g.toc = 1'($urandom); g.idx = 3'($urandom);
    if (y.evloss) begin g.mode = 3'($urandom_range(0, 5)); to_done(); return; end
    if (y.cp) begin
      m.ccc_en = 1'b1; m.path = 3'd0; step(); run_phase(y, fin); return;
    end
    if (y.idx >= 4) begin m.err = 1'b1; to_done(); return; end
    if (m_restart) begin
      m.ccc_en = 1'b1; m.path = 3'd0; m.addr = 12'd450; step();
      if (pin_on) begin
        pin(); chk("dummy_addr", o_regf_addr_special, 450); chk("dummy_ccc_en", o_ccc_en, 1);
      end
      for (int k = 1; k <= T; k++) begin
        if (k == y.drst) begin
          g.rst = 1'b1; g.en = 1'b0; reset_model(); step(); g.rst = 1'b0; return;
        end
        if (k == y.dd) begin
          g.ccc_done = 1'b1; m.ccc_en = 1'b0; m.addr = 12'd1000; m_restart = 1'b0; step();
          m.eng_en = 4'd1 << y.idx; m.path = y.idx + 3'd1; step();
          run_phase(y, fin); return;
        end
        if (k == T) begin drop(); m.err = 1'b1; to_done(); return; end
        noise(); step();
      end
    end
    m.eng_en = 4'd1 << y.idx; m.path = y.idx + 3'd1; step();
    if (pin_on) begin
      pin(); chk("first_eng_en", o_eng_en, 1); chk("first_path", o_path_sel, 1);
    end
    run_phase(y, fin);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cp = 1'b0; toc = 1'b0; idx = '0; mode = 3'd6;
    ccc_done = 1'b0; eng_done = '0;
    checks = 0; errors = 0; done_seen = 0; cyc = 0; pin_on = 1'b0;
    g = '0; g.rst = 1'b1; g.mode = 3'd6; reset_model();
    step(); step(); g.rst = 1'b0; idle(2);
    pin(); chk("reset_addr", o_regf_addr_special, 1000);
    chk("reset_cnt", o_xfer_cnt, 0); chk("reset_err", o_err, 0);

    // single DDR write
    pin_on = 1'b1; start(); desc(mk(0, 1, 0, 10), ended); pin_on = 1'b0;
    pin(); chk("ddr_cnt", o_xfer_cnt, 1); chk("ddr_path", o_path_sel, 1); chk("ddr_err", o_err, 0);
    idle(2);

    // CCC restart followed by DDR on engine 2 through the dummy phase
    pin_on = 1'b1; start(); desc(mk(1, 0, 0, 5), ended);
    x = mk(0, 1, 2, 6); x.dd = 4; desc(x, ended); pin_on = 1'b0;
    pin(); chk("ccc_ddr_cnt", o_xfer_cnt, 3); chk("ccc_ddr_path", o_path_sel, 3);
    chk("ccc_ddr_addr", o_regf_addr_special, 1000);
    idle(2);

    // back-to-back restarts, one done pulse
    base = done_seen; start();
    desc(mk(0, 0, 0, 4), ended); desc(mk(0, 0, 1, 7), ended); desc(mk(0, 1, 3, 3), ended);
    pin(); chk("b2b_cnt", o_xfer_cnt, 6); chk("b2b_path", o_path_sel, 4);
    idle(2); pin(); chk("b2b_done_pulses", done_seen - base, 1);

    // watchdog expiry, then done on the expiry cycle and one before it
    start(); desc(mk(0, 1, 1, 0), ended);
    pin(); chk("timeout_err", o_err, 1); chk("timeout_cnt", o_xfer_cnt, 6);
    idle(1); start(); desc(mk(0, 1, 2, T), ended);
    pin(); chk("late_done_err", o_err, 0); chk("late_done_cnt", o_xfer_cnt, 7);
    idle(1); start(); desc(mk(0, 1, 2, T - 1), ended); idle(1);

    // invalid index, then mode loss mid-run
    start(); desc(mk(0, 1, 5, 3), ended);
    pin(); chk("inv_err", o_err, 1); chk("inv_eng_en", o_eng_en, 0); chk("inv_cnt", o_xfer_cnt, 8);
    idle(1); x = mk(0, 1, 1, 10); x.loss = 4; start(); desc(x, ended);
    pin(); chk("loss_cnt", o_xfer_cnt, 8); chk("loss_err", o_err, 0);
    idle(2);

    // abort mid-CCC, then reset mid-dummy
    x = mk(1, 1, 0, 10); x.abort_at = 3; start(); desc(x, ended);
    pin(); chk("abort_ccc_en", o_ccc_en, 0); chk("abort_cnt", o_xfer_cnt, 8);
    idle(3); start(); desc(mk(1, 0, 0, 2), ended);
    x = mk(0, 1, 1, 5); x.dd = 6; x.drst = 3; desc(x, ended);
    pin(); chk("rst_addr", o_regf_addr_special, 1000); chk("rst_cnt", o_xfer_cnt, 0);
    chk("rst_path", o_path_sel, 0);
    idle(2);

    // randomized descriptor bursts
    repeat (150) begin
      start();
      for (int i = 0; i < 4; i++) begin
        int r, a;
        x.cp  = ($urandom_range(0, 9) < 3);
        x.toc = (i == 3) ? 1'b1 : ($urandom_range(0, 2) == 0);
        x.idx = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
        r = $urandom_range(0, 19);
        x.d = (r == 0) ? 0 : (r == 1) ? T : $urandom_range(1, T - 1);
        x.loss = ($urandom_range(0, 19) == 0) ? $urandom_range(1, T) : 0;
        x.abort_at = 0;
        if ($urandom_range(0, 19) == 0) begin
          a = $urandom_range(1, T - 1);
          if (x.d == 0 || a < x.d) x.abort_at = a;
        end
        x.dd = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
        x.drst = 0;
        x.evloss = ($urandom_range(0, 29) == 0);
        desc(x, ended);
        if (ended) break;
      end
      idle($urandom_range(1, 3));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("trace_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
